// File: rtl/hilo_div_ctrl.sv
// ============================================================================
// Module   : hilo_div_ctrl
// Purpose  : HI/LO owner and sequencer for the 32-cycle restoring divider.
//            Optional DIVU support with HILO_DIVU_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_div_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
`ifdef HILO_DIVU_EN
    input  logic        is_unsigned,
`endif
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wr_data,
    output logic        div_rst,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc
);

    localparam int c_CNT_W = ($clog2(DIV_CYCLES) > 0) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4,
        S_ZERO = 3'd5
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sa;
    logic               r_sb;

    logic               w_unsigned;
    logic               w_sa;
    logic               w_sb;
    logic [31:0]        w_mag_a;
    logic [31:0]        w_mag_b;
    logic [31:0]        w_q_fix;
    logic [31:0]        w_r_fix;

`ifdef HILO_DIVU_EN
    assign w_unsigned = is_unsigned;
`else
    assign w_unsigned = 1'b0;
`endif

    // Unsigned mode clears the sign flags, so magnitudes and fix-up become identity.
    assign w_sa    = op_a[31] & ~w_unsigned;
    assign w_sb    = op_b[31] & ~w_unsigned;
    assign w_mag_a = w_sa ? (32'd0 - op_a) : op_a;
    assign w_mag_b = w_sb ? (32'd0 - op_b) : op_b;
    assign w_q_fix = (r_sa ^ r_sb) ? (32'd0 - div_quot) : div_quot;
    assign w_r_fix = r_sa ? (32'd0 - div_rem) : div_rem;

    // Control-unit flags are registered from the current state, so they trail it by one edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            div_rst      <= 1'b1;
            div_a        <= 32'd0;
            div_b        <= 32'd0;
            hi           <= 32'd0;
            lo           <= 32'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_zero_exc <= 1'b0;
        end else begin
            busy         <= (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_FIX);
            done         <= (r_state == S_DONE);
            div_zero_exc <= (r_state == S_ZERO);

            case (r_state)
                S_IDLE: begin
                    if (hi_we) hi <= wr_data;
                    if (lo_we) lo <= wr_data;
                    if (start) begin
                        r_sa <= w_sa;
                        r_sb <= w_sb;
                        if (op_b == 32'd0) begin
                            r_state <= S_ZERO;
                        end else begin
                            r_state <= S_LOAD;
                            div_rst <= 1'b1;
                            div_a   <= w_mag_a;
                            div_b   <= w_mag_b;
                        end
                    end
                end
                S_LOAD: begin
                    r_cnt   <= '0;
                    div_rst <= 1'b0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    lo      <= w_q_fix;
                    hi      <= w_r_fix;
                    div_rst <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                S_ZERO:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Sequencer that sits between the control unit and the 32-cycle restoring unsigned divider, and owns the HI/LO registers.
- Captures signed operands on `start`, hands magnitudes to the divider, and times the 32 divider cycles.
- Applies sign correction and writes LO=quotient, HI=remainder.
- Raises `busy` for control-unit stall, a one-cycle `done`, and a one-cycle divide-by-zero exception. Also services MTHI/MTLO writes.

Parameters:
- DIV_CYCLES, 32, number of divider clock cycles between divider reset release and result sampling.

Ports:
- clock  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- start  input  1  begin division; sampled only in IDLE
- op_a  input  32  dividend (two's complement)
- op_b  input  32  divisor (two's complement)
- hi_we  input  1  MTHI write strobe
- lo_we  input  1  MTLO write strobe
- wr_data  input  32  MTHI/MTLO data
- div_rst  output  1  reset to divider; high during `reset` and in LOAD
- div_a  output  32  dividend magnitude to divider
- div_b  output  32  divisor magnitude to divider
- div_quot  input  32  divider quotient
- div_rem  input  32  divider remainder
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  high in LOAD, RUN, FIX
- done  output  1  one-cycle pulse, result written
- div_zero_exc  output  1  one-cycle pulse, divisor was zero

Behaviour:
- Reset values:
  - State IDLE, counter 0.
  - hi=0, lo=0, busy=0, done=0, div_zero_exc=0.
  - div_a=0, div_b=0, div_rst=1.
- State IDLE:
  - On start=1, capture op_a, op_b, sign flags sa=op_a[31], sb=op_b[31].
  - If op_b==0: go to ZERO. Otherwise go to LOAD.
- State LOAD (1 cycle):
  - div_rst=1.
  - div_a=|op_a|, div_b=|op_b|, computed as two's-complement negation when the sign bit is set. 0x80000000 maps to 0x80000000 unsigned.
  - Counter cleared; go to RUN.
- State RUN:
  - div_rst=0; div_a/div_b held.
  - Counter increments each cycle. When counter==DIV_CYCLES-1, go to FIX.
- State FIX (1 cycle):
  - q = div_quot, or -div_quot if sa^sb.
  - r = div_rem, or -div_rem if sa. The remainder takes the sign of the dividend.
  - Write lo=q, hi=r; go to DONE.
- State DONE (1 cycle): done=1, busy=0; go to IDLE.
- State ZERO (1 cycle): div_zero_exc=1, hi/lo unchanged, divider not started; go to IDLE.
- Latency: with start sampled at edge E0, done is high during the cycle after edge E35. The divider sees DIV_CYCLES+1 clocks, including the first result edge.
- Overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No exception.
- start while busy or in DONE/ZERO: ignored, no queueing.
- hi_we/lo_we:
  - Applied only in IDLE; ignored otherwise.
  - If a write and start occur in the same IDLE cycle, the write is applied and start is captured. The later FIX overwrites both registers.
  - hi_we and lo_we together write both registers with wr_data.
- reset mid-operation:
  - Abandon the division and return to IDLE, with all outputs at their reset values.
  - Takes effect on the next edge.
  - No done or div_zero_exc pulse.

Optional Feature:
- Macro: HILO_DIVU_EN.
- Defined:
  - Adds port `is_unsigned`, input, 1 bit, sampled with start.
  - When set, sa=sb=0 and operands pass unmodified, so no magnitude conversion or sign fix is applied. This implements DIVU.
- Undefined: port absent; all divisions are signed.

Test Plan:
1. op_a=7, op_b=2, start at E0 -> busy=1 from E1; done during cycle after E35; lo=3, hi=1.
2. op_a=-7 (0xFFFFFFF9), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also op_a=7, op_b=-2 -> lo=0xFFFFFFFD, hi=1.
3. Preload hi=0xAAAA via MTHI; op_a=100, op_b=0 -> div_zero_exc pulse one cycle after start edge; busy never set; hi=0xAAAA, lo unchanged.
4. Start 50/5, assert reset at RUN counter=10 -> next cycle idle with hi=lo=0 and busy=0. Restart 50/5 -> lo=10, hi=0.
5. Second start and lo_we=1 (wr_data=0x1234) during RUN -> both ignored; first result lands. lo_we in IDLE then writes lo=0x1234.
6. With HILO_DIVU_EN, is_unsigned=1, op_a=0xFFFFFFFF, op_b=2 -> lo=0x7FFFFFFF, hi=1. The same operands signed give lo=0, hi=0xFFFFFFFF.
